vram_bus_arbiter: RTL and testbench

Shares the single internal bus-master port (19-bit address, 8-bit data, one-cycle strobe) among several requesters: the 6502 host interface, DMA/fill engines and video fetch helpers. Each requester has a one-deep pending slot. Requester 0 (host) has fixed priority; the rest are served round-robin. The arbiter issues at most one access per clk, tags it, and routes read data back to its originating requester.

---
 rtl/vram_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_vram_bus_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_bus_arbiter.sv
// vram_bus_arbiter
// Shares the single internal bus-master port among NUM_REQ requesters.
// Requester 0 (the 6502 host) has fixed priority; requesters 1..NUM_REQ-1
// are served round-robin. Each requester owns a one-deep pending slot so a
// strobe that loses arbitration is remembered. At most one access is issued
// per clock. Reads are tagged with the requester id, and the read data is
// routed back to that requester RD_LAT cycles after the issue.

module vram_bus_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 19,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_wrdata,
  input  logic [NUM_REQ-1:0]        req_strobe,
  input  logic [NUM_REQ-1:0]        req_write,
  output logic [NUM_REQ-1:0]        req_busy,
  output logic [NUM_REQ-1:0]        req_rdvalid,
  output logic [NUM_REQ-1:0]        req_overrun,
  output logic [7:0]                rddata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [7:0]                mem_wrdata,
  output logic                      mem_strobe,
  output logic                      mem_write,
  input  logic [7:0]                mem_rddata
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Pending slots: one remembered request per requester
  logic [NUM_REQ-1:0] pending;
  logic [ADDR_W-1:0]  pend_addr   [NUM_REQ];
  logic [7:0]         pend_wrdata [NUM_REQ];
  logic [NUM_REQ-1:0] pend_write;

  // Arbitration
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant_oh;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_next;

  // Fields of the winning request
  logic [ADDR_W-1:0]  sel_addr;
  logic [7:0]         sel_wrdata;
  logic               sel_write;

  // Id of the access currently on the mem_* port
  logic [ID_W-1:0]    mem_id;

  // Read tag pipeline, stage RD_LAT-1 lines up with valid mem_rddata
  logic [RD_LAT-1:0]  tag_valid;
  logic [ID_W-1:0]    tag_id [RD_LAT];

  assign cand     = pending | req_strobe;
  assign req_busy = pending;

  // Pick at most one winner: host first, otherwise the first candidate
  // found scanning upward from the round-robin pointer, wrapping to 1.
  always_comb begin
    int idx;
    idx         = 0;
    grant_oh    = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    rr_next     = rr_ptr;
    if (cand[0]) begin
      grant_oh[0] = 1'b1;
      grant_valid = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        idx = ((int'(rr_ptr) + NUM_REQ - 2 + k) % (NUM_REQ - 1)) + 1;
        if (!grant_valid && cand[idx]) begin
          grant_valid   = 1'b1;
          grant_oh[idx] = 1'b1;
          grant_id      = ID_W'(idx);
          rr_next       = (idx == NUM_REQ - 1) ? ID_W'(1) : ID_W'(idx + 1);
        end
      end
    end
  end

  // Gather the winner's fields; a held request beats a same-cycle strobe
  always_comb begin
    sel_addr   = '0;
    sel_wrdata = '0;
    sel_write  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        if (pending[i]) begin
          sel_addr   = pend_addr[i];
          sel_wrdata = pend_wrdata[i];
          sel_write  = pend_write[i];
        end else begin
          sel_addr   = req_addr[i*ADDR_W +: ADDR_W];
          sel_wrdata = req_wrdata[i*8 +: 8];
          sel_write  = req_write[i];
        end
      end
    end
  end

  // Load, clear or overwrite each pending slot and flag overwrites
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      pend_write  <= '0;
      req_overrun <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_addr[i]   <= '0;
        pend_wrdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_overrun[i] <= req_strobe[i] & pending[i] & ~grant_oh[i];
        if (req_strobe[i] && (pending[i] || !grant_oh[i])) begin
          pending[i]     <= 1'b1;
          pend_addr[i]   <= req_addr[i*ADDR_W +: ADDR_W];
          pend_wrdata[i] <= req_wrdata[i*8 +: 8];
          pend_write[i]  <= req_write[i];
        end else if (grant_oh[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Register the granted access onto the bus and advance the RR pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_strobe <= 1'b0;
      mem_addr   <= '0;
      mem_wrdata <= '0;
      mem_write  <= 1'b0;
      mem_id     <= '0;
      rr_ptr     <= ID_W'(1);
    end else begin
      mem_strobe <= grant_valid;
      rr_ptr     <= rr_next;
      if (grant_valid) begin
        mem_addr   <= sel_addr;
        mem_wrdata <= sel_wrdata;
        mem_write  <= sel_write;
        mem_id     <= grant_id;
      end
    end
  end

  // Carry read tags alongside the memory latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_valid[0] <= mem_strobe & ~mem_write;
      tag_id[0]    <= mem_id;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  // Capture returning read data and pulse rdvalid for its owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_rdvalid <= '0;
      rddata      <= '0;
    end else begin
      req_rdvalid <= '0;
      if (tag_valid[RD_LAT-1]) begin
        rddata <= mem_rddata;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (tag_id[RD_LAT-1] == ID_W'(i)) begin
            req_rdvalid[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// tb_vram_bus_arbiter
// Directed scenarios plus randomized traffic. A request-level model of the
// arbiter (pending slots, host priority, round-robin distance, read returns
// scheduled by absolute cycle) predicts every output each cycle; a few
// hand-computed literal checks pin the model itself.

module tb_vram_bus_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 19;
  localparam int RD_LAT  = 1;
  localparam int MAXC    = 4096;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*8-1:0]      req_wrdata;
  logic [NUM_REQ-1:0]        req_strobe;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_busy;
  logic [NUM_REQ-1:0]        req_rdvalid;
  logic [NUM_REQ-1:0]        req_overrun;
  logic [7:0]                rddata;
  logic [ADDR_W-1:0]         mem_addr;
  logic [7:0]                mem_wrdata;
  logic                      mem_strobe;
  logic                      mem_write;
  logic [7:0]                mem_rddata;

  vram_bus_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_addr   (req_addr),
    .req_wrdata (req_wrdata),
    .req_strobe (req_strobe),
    .req_write  (req_write),
    .req_busy   (req_busy),
    .req_rdvalid(req_rdvalid),
    .req_overrun(req_overrun),
    .rddata     (rddata),
    .mem_addr   (mem_addr),
    .mem_wrdata (mem_wrdata),
    .mem_strobe (mem_strobe),
    .mem_write  (mem_write),
    .mem_rddata (mem_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Stimulus for the cycle about to be driven
  logic [NUM_REQ-1:0] s_stb;
  logic [NUM_REQ-1:0] s_wr;
  logic [ADDR_W-1:0]  s_addr [NUM_REQ];
  logic [7:0]         s_data [NUM_REQ];
  logic [7:0]         s_mrd;
  logic               s_rst;

  // Model state
  bit                 m_pv [NUM_REQ];
  logic [ADDR_W-1:0]  m_pa [NUM_REQ];
  logic [7:0]         m_pd [NUM_REQ];
  bit                 m_pw [NUM_REQ];
  int                 m_rr;
  bit                 rd_due [MAXC];
  int                 rd_who [MAXC];

  // Expected outputs for the current cycle
  logic [NUM_REQ-1:0] e_busy, e_rdvalid, e_overrun;
  logic [7:0]         e_rddata, e_mwd;
  logic [ADDR_W-1:0]  e_maddr;
  logic               e_mstb, e_mwr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      m_pv[i] = 1'b0;
      m_pa[i] = '0;
      m_pd[i] = '0;
      m_pw[i] = 1'b0;
    end
    m_rr = 1;
    foreach (rd_due[j]) rd_due[j] = 1'b0;
    e_busy    = '0;
    e_rdvalid = '0;
    e_overrun = '0;
    e_rddata  = '0;
    e_mwd     = '0;
    e_maddr   = '0;
    e_mstb    = 1'b0;
    e_mwr     = 1'b0;
  endfunction

  // Advance the request-level model by one cycle using this cycle's stimulus
  task automatic model_step();
    int g;
    int best_d;
    int d;
    logic [NUM_REQ-1:0] nrv;
    logic [NUM_REQ-1:0] nov;
    if (s_rst) begin
      model_reset();
      return;
    end
    nrv = '0;
    if (cyc >= RD_LAT && rd_due[cyc-RD_LAT]) begin
      nrv[rd_who[cyc-RD_LAT]] = 1'b1;
      e_rddata = s_mrd;
    end
    g = -1;
    if (m_pv[0] || s_stb[0]) begin
      g = 0;
    end else begin
      best_d = NUM_REQ;
      for (int i = 1; i < NUM_REQ; i++) begin
        if (m_pv[i] || s_stb[i]) begin
          d = (i - m_rr + NUM_REQ - 1) % (NUM_REQ - 1);
          if (d < best_d) begin
            best_d = d;
            g = i;
          end
        end
      end
    end
    e_mstb = (g >= 0);
    if (g >= 0) begin
      if (m_pv[g]) begin
        e_maddr = m_pa[g];
        e_mwd   = m_pd[g];
        e_mwr   = m_pw[g];
      end else begin
        e_maddr = s_addr[g];
        e_mwd   = s_data[g];
        e_mwr   = s_wr[g];
      end
      if (!e_mwr) begin
        rd_due[cyc+1] = 1'b1;
        rd_who[cyc+1] = g;
      end
      if (g > 0) m_rr = (g == NUM_REQ - 1) ? 1 : g + 1;
    end
    nov = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_stb[i]) begin
        if (m_pv[i] && g != i) nov[i] = 1'b1;
        if (!(g == i && !m_pv[i])) begin
          m_pv[i] = 1'b1;
          m_pa[i] = s_addr[i];
          m_pd[i] = s_data[i];
          m_pw[i] = s_wr[i];
        end
      end else if (g == i) begin
        m_pv[i] = 1'b0;
      end
      e_busy[i] = m_pv[i];
    end
    e_rdvalid = nrv;
    e_overrun = nov;
  endtask

  task automatic check_output();
    cmp("busy",       req_busy,    e_busy);
    cmp("rdvalid",    req_rdvalid, e_rdvalid);
    cmp("overrun",    req_overrun, e_overrun);
    cmp("rddata",     rddata,      e_rddata);
    cmp("mem_strobe", mem_strobe,  e_mstb);
    cmp("mem_addr",   mem_addr,    e_maddr);
    cmp("mem_wrdata", mem_wrdata,  e_mwd);
    cmp("mem_write",  mem_write,   e_mwr);
  endtask

  task automatic apply_stimulus();
    rst = s_rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = s_addr[i];
      req_wrdata[i*8 +: 8]         = s_data[i];
    end
    req_strobe = s_stb;
    req_write  = s_wr;
    mem_rddata = s_mrd;
  endtask

  task automatic clear_stim();
    s_stb = '0;
    s_wr  = '0;
    s_rst = 1'b0;
    s_mrd = 8'($urandom);
    for (int i = 0; i < NUM_REQ; i++) begin
      s_addr[i] = ADDR_W'($urandom);
      s_data[i] = 8'($urandom);
    end
  endtask

  // One clock: check this cycle's outputs, then drive this cycle's inputs
  task automatic tick();
    @(negedge clk);
    check_output();
    apply_stimulus();
    model_step();
    cyc++;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    req_addr   = '0;
    req_wrdata = '0;
    req_strobe = '0;
    req_write  = '0;
    mem_rddata = '0;
    model_reset();
    clear_stim();
    s_rst = 1'b1;
    tick();
    tick();
    clear_stim();
    tick();
    tick();
    cmp("reset_busy",   req_busy,   0);
    cmp("reset_strobe", mem_strobe, 0);
    cmp("reset_addr",   mem_addr,   0);

    // Single host read
    clear_stim(); s_stb = 3'b001; s_addr[0] = 19'h1FA00; tick();
    clear_stim(); tick();
    cmp("host_rd_strobe", mem_strobe, 1);
    cmp("host_rd_addr",   mem_addr,   19'h1FA00);
    cmp("host_rd_busy",   req_busy,   0);
    clear_stim(); s_mrd = 8'h5A; tick();
    cmp("host_rd_early",  req_rdvalid, 0);
    clear_stim(); tick();
    cmp("host_rd_valid",  req_rdvalid, 3'b001);
    cmp("host_rd_data",   rddata,      8'h5A);
    clear_stim(); tick();
    clear_stim(); tick();

    // Contention, then round-robin pointer back at 1
    clear_stim(); s_stb = 3'b111;
    s_addr[0] = 19'h10; s_addr[1] = 19'h11; s_addr[2] = 19'h12; tick();
    clear_stim(); tick();
    cmp("cont_first", mem_addr, 19'h10);
    cmp("cont_busy1", req_busy, 3'b110);
    clear_stim(); tick();
    cmp("cont_second", mem_addr, 19'h11);
    cmp("cont_busy2",  req_busy, 3'b100);
    clear_stim(); s_stb = 3'b110; s_addr[1] = 19'h21; s_addr[2] = 19'h22; tick();
    cmp("cont_third", mem_addr, 19'h12);
    cmp("cont_busy3", req_busy, 0);
    clear_stim(); tick();
    cmp("rr_wrap_1", mem_addr, 19'h21);
    clear_stim(); tick();
    cmp("rr_wrap_2", mem_addr, 19'h22);
    clear_stim(); tick();

    // Round-robin fairness: 1 and 2 strobe every cycle
    for (int k = 0; k < 14; k++) begin
      clear_stim();
      if (k < 10) begin
        s_stb = 3'b110; s_wr = 3'b110;
        s_addr[1] = 19'h31; s_addr[2] = 19'h32;
      end
      tick();
      if (k >= 1 && k <= 12) begin
        cmp("rr_alt_strobe", mem_strobe, 1);
        cmp("rr_alt_addr",   mem_addr, (k % 2 == 1) ? 19'h31 : 19'h32);
      end
      if (k == 13) cmp("rr_alt_done", mem_strobe, 0);
    end

    // Host priority over a pending requester 1
    for (int k = 0; k < 7; k++) begin
      clear_stim();
      if (k < 4) begin
        s_stb[0] = 1'b1; s_addr[0] = ADDR_W'(32'h40 + k);
      end
      if (k == 0) begin
        s_stb[1] = 1'b1; s_addr[1] = 19'h4F;
      end
      tick();
      if (k >= 1 && k <= 4) cmp("host_pri_addr", mem_addr, 32'h40 + k - 1);
      if (k == 4) cmp("host_pri_busy", req_busy, 3'b010);
      if (k == 5) begin
        cmp("host_pri_req1", mem_addr, 19'h4F);
        cmp("host_pri_idle", req_busy, 0);
      end
      cmp("host_pri_ovr", req_overrun, 0);
    end

    // Overrun on requester 2
    clear_stim(); s_stb = 3'b101; s_wr = 3'b101;
    s_addr[0] = 19'h50; s_addr[2] = 19'h52; s_data[2] = 8'h11; tick();
    clear_stim(); s_stb = 3'b101; s_wr = 3'b101;
    s_addr[0] = 19'h51; s_addr[2] = 19'h53; s_data[2] = 8'h22; tick();
    cmp("ovr_not_yet", req_overrun, 0);
    clear_stim(); tick();
    cmp("ovr_pulse", req_overrun, 3'b100);
    cmp("ovr_busy",  req_busy,    3'b100);
    clear_stim(); tick();
    cmp("ovr_addr",  mem_addr,    19'h53);
    cmp("ovr_data",  mem_wrdata,  8'h22);
    cmp("ovr_write", mem_write,   1);
    cmp("ovr_once",  req_overrun, 0);
    clear_stim(); tick();
    cmp("ovr_single_issue", mem_strobe, 0);

    // Reset while a read is in flight
    clear_stim(); s_stb = 3'b010; s_wr = 3'b010; s_addr[1] = 19'h61; tick();
    clear_stim(); s_stb = 3'b001; s_addr[0] = 19'h60; tick();
    clear_stim(); tick();
    cmp("rst_rd_issue", mem_strobe, 1);
    cmp("rst_rd_addr",  mem_addr,   19'h60);
    clear_stim(); s_rst = 1'b1; tick();
    #1;
    cmp("rst_busy",    req_busy,    0);
    cmp("rst_rdvalid", req_rdvalid, 0);
    cmp("rst_overrun", req_overrun, 0);
    cmp("rst_rddata",  rddata,      0);
    cmp("rst_strobe",  mem_strobe,  0);
    cmp("rst_addr",    mem_addr,    0);
    cmp("rst_wrdata",  mem_wrdata,  0);
    cmp("rst_write",   mem_write,   0);
    clear_stim(); tick();
    cmp("rst_no_rdvalid", req_rdvalid, 0);
    clear_stim(); s_stb = 3'b110; s_wr = 3'b110;
    s_addr[1] = 19'h71; s_addr[2] = 19'h72; tick();
    clear_stim(); tick();
    cmp("rst_rr_first",  mem_addr, 19'h71);
    clear_stim(); tick();
    cmp("rst_rr_second", mem_addr, 19'h72);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      clear_stim();
      for (int i = 0; i < NUM_REQ; i++) begin
        s_stb[i] = ($urandom_range(0, 2) == 0);
      end
      s_wr  = NUM_REQ'($urandom);
      s_rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    for (int n = 0; n < 6; n++) begin
      clear_stim();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
